// File: rtl/curveball_audio_pkg.sv
// Shared types and constants for the sound-effect scheduler.
package curveball_audio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_HOLD  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4
   } sfx_state_t;

   localparam int CMD_W_DEFAULT = 16;

   localparam logic [CMD_W_DEFAULT-1:0] SILENCE_CMD = 16'h0000;

endpackage

// File: rtl/audio_sfx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: search begins just after the previous winner.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_winner,
   output logic [N_REQ-1:0] winner,
   output logic             valid
);

   logic [IDX_W-1:0] w_idx;
   logic             w_take;
   logic             w_found;

   // Walk requesters in rotated order and keep only the first one found.
   always_comb begin
      winner  = {N_REQ{1'b0}};
      w_found = 1'b0;
      w_idx   = {IDX_W{1'b0}};
      w_take  = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx          = IDX_W'((int'(last_winner) + k) % N_REQ);
         w_take         = ~w_found & req[w_idx];
         winner[w_idx]  = winner[w_idx] | w_take;
         w_found        = w_found | w_take;
      end
      valid = w_found;
   end

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Sound-effect scheduler: arbitrates requesters, strobes one command, holds it,
// then emits a silence command and an idle gap before accepting new work.
module audio_sfx_scheduler
   import curveball_audio_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int CMD_W       = CMD_W_DEFAULT,
   parameter int HOLD_CYCLES = 1000000,
   parameter int GAP_CYCLES  = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CMD_W-1:0] req_cmd,
   output logic [N_REQ-1:0]       grant,
   output logic                   cs,
   output logic [CMD_W-1:0]       data,
   output logic                   busy
);

   localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   sfx_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_last;
   logic [N_REQ-1:0] r_grant;
   logic             r_cs;
   logic [CMD_W-1:0] r_data;
   logic             r_busy;

   logic [N_REQ-1:0] w_win;
   logic             w_valid;
   logic [IDX_W-1:0] w_win_idx;
   logic [CMD_W-1:0] w_cmd;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req         (req),
      .last_winner (r_last),
      .winner      (w_win),
      .valid       (w_valid)
   );

   // One-hot winner to index and command select; the winner is one-hot so OR-ing is exact.
   always_comb begin
      w_win_idx = {IDX_W{1'b0}};
      w_cmd     = {CMD_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         w_win_idx = w_win_idx | (w_win[i] ? IDX_W'(i) : {IDX_W{1'b0}});
         w_cmd     = w_cmd | (w_win[i] ? req_cmd[i*CMD_W +: CMD_W] : {CMD_W{1'b0}});
      end
   end

   // Scheduler FSM, play/gap counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_last  <= IDX_W'(N_REQ - 1);
         r_grant <= {N_REQ{1'b0}};
         r_cs    <= 1'b0;
         r_data  <= {CMD_W{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en && w_valid) begin
                  r_state <= ST_ISSUE;
                  r_grant <= w_win;
                  r_cs    <= 1'b1;
                  r_data  <= w_cmd;
                  r_busy  <= 1'b1;
                  r_last  <= w_win_idx;
               end else begin
                  r_grant <= {N_REQ{1'b0}};
                  r_cs    <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_HOLD;
               r_grant <= {N_REQ{1'b0}};
               r_cs    <= 1'b0;
               r_cnt   <= CNT_W'(HOLD_CYCLES);
            end
            ST_HOLD: begin
               // Enable drop wins over everything, including the final hold cycle.
               if (!en || ((r_cnt == CNT_W'(1)) && !w_valid)) begin
                  r_state <= ST_STOP;
                  r_cs    <= 1'b1;
                  r_data  <= CMD_W'(SILENCE_CMD);
                  r_cnt   <= {CNT_W{1'b0}};
               end else if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_ISSUE;
                  r_grant <= w_win;
                  r_cs    <= 1'b1;
                  r_data  <= w_cmd;
                  r_last  <= w_win_idx;
                  r_cnt   <= {CNT_W{1'b0}};
               end else begin
                  r_cnt   <= r_cnt - CNT_W'(1);
               end
            end
            ST_STOP: begin
               r_state <= ST_GAP;
               r_cs    <= 1'b0;
               r_cnt   <= CNT_W'(GAP_CYCLES);
            end
            ST_GAP: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= {CNT_W{1'b0}};
               end else begin
                  r_cnt   <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= {N_REQ{1'b0}};
               r_cs    <= 1'b0;
               r_busy  <= 1'b0;
               r_cnt   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign grant = r_grant;
   assign cs    = r_cs;
   assign data  = r_data;
   assign busy  = r_busy;

endmodule

// File: doc/audio_sfx_scheduler.md
AUDIO_SFX_SCHEDULER -- requirements
Module: audio_sfx_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of sound-effect requesters.
REQ-002 SHALL have parameter CMD_W, default 16: audio command width.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1000000: cycles each granted command plays; legal range 1 or more.
REQ-004 SHALL have parameter GAP_CYCLES, default 1000: minimum idle cycles after a silence command; legal range 1 or more.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 en  input  1  scheduler enable; deassertion stops playback.
REQ-008 req  input  N_REQ  per-requester play request, level, held until granted.
REQ-009 req_cmd  input  N_REQ*CMD_W  per-requester command; slice i is req_cmd[i*CMD_W +: CMD_W].
REQ-010 grant  output  N_REQ  one-hot, one-cycle acknowledge to the winning requester.
REQ-011 cs  output  1  one-cycle command strobe to the audio controller.
REQ-012 data  output  CMD_W  command word, valid when cs=1.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ISSUE, HOLD, STOP and GAP.
REQ-015 All outputs SHALL be registered.
REQ-016 IDLE: at an edge where en=1 and req is nonzero, SHALL arbitrate, latch the winner's req_cmd, and enter ISSUE.
REQ-017 Arbitration SHALL be round-robin: search starts at last_winner+1 (mod N_REQ), and the first requester with req set wins.
REQ-018 ISSUE: SHALL last exactly 1 cycle, with cs=1, data=the latched command and grant[winner]=1, then enter HOLD.
REQ-019 Latency from req sampled high in IDLE to cs/grant SHALL be 1 cycle.
REQ-020 HOLD: SHALL last exactly HOLD_CYCLES cycles, counted by a down-counter of width clog2(HOLD_CYCLES+1); cs=0 and grant=0 throughout.
REQ-021 On the last HOLD cycle with en=1 and req nonzero, SHALL arbitrate and go directly to ISSUE, giving back-to-back play with no STOP or GAP.
REQ-022 On the last HOLD cycle with req zero, SHALL enter STOP.
REQ-023 en=0 sampled in any HOLD cycle SHALL abort HOLD and enter STOP on the next cycle.
REQ-024 STOP: SHALL last 1 cycle with cs=1 and data=0 (silence), then enter GAP.
REQ-025 GAP: SHALL last exactly GAP_CYCLES cycles, ignore req, then enter IDLE.
REQ-026 en=0 SHALL NOT interrupt ISSUE, STOP or GAP.
REQ-027 In IDLE, en=0 SHALL block arbitration.
REQ-028 req deasserted before grant SHALL be dropped with no grant issued.
REQ-029 A req_cmd value of 0 SHALL be issued as-is and still occupy the full HOLD period.
REQ-030 last_winner SHALL update only on a grant.
REQ-031 data SHALL hold its last value while cs=0.

Reset
REQ-032 rst=0 SHALL asynchronously force state=IDLE, grant=0, cs=0, data=0, busy=0, counter=0 and last_winner=N_REQ-1, so requester 0 wins first.
REQ-033 Reset asserted mid-HOLD SHALL NOT emit a silence strobe.
REQ-034 Requests SHALL be honoured from the first edge after rst deasserts.

Structure
REQ-035 Package curveball_audio_pkg SHALL hold the state enumeration, CMD_W default and the SILENCE_CMD constant (0).
REQ-036 Round-robin selection SHALL live in a sub-module rr_arbiter, with inputs req and last_winner and outputs a one-hot winner and a valid flag; it is purely combinational.
REQ-037 Counter and FSM logic SHALL reside in audio_sfx_scheduler.

Verification (N_REQ=4, HOLD_CYCLES=8, GAP_CYCLES=3)
REQ-038 Single play: req=0001 with cmd0=16'h1234 from reset -> next cycle cs=1, data=1234, grant=0001; 8 HOLD cycles; STOP with cs=1, data=0; 3 GAP cycles; busy falls after 13 cycles total.
REQ-039 Round-robin: req=1111 held, grant removes each winner -> grants in order 0001, 0010, 0100, 1000, each 9 cycles apart, with no STOP strobe between them.
REQ-040 Enable abort: en dropped in the 3rd HOLD cycle -> STOP strobe (data=0) on the next cycle, then GAP, then IDLE; a pending req is not granted until en=1.
REQ-041 GAP masking: req0 raised during GAP -> no grant until IDLE; grant 1 cycle after GAP ends.
REQ-042 Async reset: rst=0 asserted mid-HOLD -> all outputs 0 immediately with no clock edge needed; after release, req=1000 and req=0001 together -> requester 0 granted first.
